idct_pixel_sink: RTL

- Receiving end of the idct output stream.
- Captures each 64-sample burst the idct core presents while its done is high, and converts each fixed-point sample to an 8-bit pixel.
- Writes each pixel to a frame-buffer write port at its raster-order address, so reconstructed QCIF frames land in memory without testbench file I/O.
- Sits between idct.dout/done and a single-port pixel RAM; tracks block position and flags frame completion and protocol faults.

---
 rtl/idct_pixel_sink.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/idct_pixel_sink.sv
// idct_pixel_sink: receiving end of the idct output stream.
// Captures each 64-sample burst presented while done is high, converts every sample to an 8-bit
// pixel and writes it to a pixel RAM port at its raster address. It also tracks the block
// position, counts finished blocks, and flags frame completion and short bursts.
// Optional feature: define IDCT_SINK_SAT_EN for signed, clamped pixel extraction. Without it,
// each pixel is a plain bit slice of the sample.
module idct_pixel_sink #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned FRAC_LSB = 10,
  parameter int unsigned IMG_W    = 176,
  parameter int unsigned IMG_H    = 144,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [DATA_W-1:0] din,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic [15:0]       blk_cnt,
  output logic              frame_done,
  output logic              err_short
);

  localparam int unsigned BlkX = IMG_W / 8;
  localparam int unsigned BlkY = IMG_H / 8;
  localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(IMG_W * 8);
  localparam logic [ADDR_W-1:0] LastCol  = ADDR_W'((BlkX - 1) * 8);
  localparam logic [ADDR_W-1:0] LastLine = ADDR_W'((BlkY - 1) * 8 * IMG_W);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

  state_e state_q, state_d;
  logic [5:0] idx_q, idx_d;
  // Address = line_base (by*8*IMG_W) + blk_off (bx*8) + row_off (row*IMG_W) + col.
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] blk_off_q, blk_off_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;
  logic adv_pend_q, adv_pend_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic frame_done_q, frame_done_d;
  logic err_short_q, err_short_d;

  // Capture stage
  logic              cap_valid_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_data_q;
  // Output stage
  logic              pix_we_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [7:0]        pix_data_q;

  logic       capture;
  logic [5:0] cap_idx;
  logic       short_exit;
  logic       advance;
  logic [ADDR_W-1:0] cap_addr_d;
  logic [7:0] pix_conv;

  // Burst FSM: decides whether this cycle captures a sample and which index it gets.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    capture    = 1'b0;
    cap_idx    = idx_q;
    short_exit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (done) begin
          capture = 1'b1;
          cap_idx = 6'd0;
          idx_d   = 6'd1;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (done) begin
          capture = 1'b1;
          if (idx_q == 6'd63) begin
            idx_d   = 6'd0;
            state_d = StDrain;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          short_exit = 1'b1;
          idx_d      = 6'd0;
          state_d    = StIdle;
        end
      end
      StDrain: begin
        if (!done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Block position, running address bases, counters and status flags.
  always_comb begin
    adv_pend_d   = capture && (cap_idx == 6'd63);
    advance      = adv_pend_q || short_exit;
    line_base_d  = line_base_q;
    blk_off_d    = blk_off_q;
    row_off_d    = row_off_q;
    blk_cnt_d    = blk_cnt_q;
    frame_done_d = 1'b0;
    err_short_d  = err_short_q || short_exit;
    cap_addr_d   = line_base_q + blk_off_q + row_off_q + {{(ADDR_W - 3){1'b0}}, cap_idx[2:0]};
    if (advance) begin
      // Capture and advance never coincide, so the row offset simply restarts here.
      row_off_d = '0;
      blk_cnt_d = blk_cnt_q + 16'd1;
      if (blk_off_q == LastCol) begin
        blk_off_d = '0;
        if (line_base_q == LastLine) begin
          line_base_d  = '0;
          frame_done_d = 1'b1;
        end else begin
          line_base_d = line_base_q + LineStep;
        end
      end else begin
        blk_off_d = blk_off_q + ADDR_W'(8);
      end
    end else if (capture && (cap_idx[2:0] == 3'd7)) begin
      row_off_d = row_off_q + RowStep;
    end
  end

  // Sample-to-pixel conversion.
`ifdef IDCT_SINK_SAT_EN
  localparam logic signed [DATA_W-1:0] PixMax = DATA_W'(255);
  logic signed [DATA_W-1:0] shifted;
  always_comb begin
    shifted = $signed(cap_data_q) >>> FRAC_LSB;
    if (shifted[DATA_W-1]) begin
      pix_conv = 8'd0;
    end else if (shifted > PixMax) begin
      pix_conv = 8'd255;
    end else begin
      pix_conv = shifted[7:0];
    end
  end
`else
  logic unused_cap_bits;
  assign unused_cap_bits = ^{cap_data_q[DATA_W-1:FRAC_LSB+8], cap_data_q[FRAC_LSB-1:0]};
  always_comb begin
    pix_conv = cap_data_q[FRAC_LSB+7:FRAC_LSB];
  end
`endif

  // State, capture stage and output stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      line_base_q  <= '0;
      blk_off_q    <= '0;
      row_off_q    <= '0;
      adv_pend_q   <= 1'b0;
      blk_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_addr_q   <= '0;
      cap_data_q   <= '0;
      pix_we_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      line_base_q  <= line_base_d;
      blk_off_q    <= blk_off_d;
      row_off_q    <= row_off_d;
      adv_pend_q   <= adv_pend_d;
      blk_cnt_q    <= blk_cnt_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      cap_valid_q  <= capture;
      if (capture) begin
        cap_addr_q <= cap_addr_d;
        cap_data_q <= din;
      end
      pix_we_q <= cap_valid_q;
      if (cap_valid_q) begin
        pix_addr_q <= cap_addr_q;
        pix_data_q <= pix_conv;
      end
    end
  end

  assign pix_we     = pix_we_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign blk_cnt    = blk_cnt_q;
  assign frame_done = frame_done_q;
  assign err_short  = err_short_q;

endmodule
